// File: rtl/adder_fault_pkg.sv
// ============================================================================
// Module      : adder_fault_pkg
// Description : Shared FSM encoding and fault-site codes for the campaign.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_fault_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [1:0] NODE_X1   = 2'd0;
  localparam logic [1:0] NODE_SUM  = 2'd1;
  localparam logic [1:0] NODE_COUT = 2'd2;

  localparam int NODES_PER_BIT = 6;

endpackage

`default_nettype wire

// File: rtl/fa_fault_cell.sv
// ============================================================================
// Module      : fa_fault_cell
// Description : Full adder whose X1, Sum or Cout node can be forced stuck.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_fault_cell
  import adder_fault_pkg::*;
(
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_cin,
  input  logic       fault_en,
  input  logic [1:0] fault_node,
  input  logic       stuck_val,
  output logic       o_sum,
  output logic       o_cout
);

  logic w_x1;

  // A stuck X1 also propagates into the carry term, as in the physical cell.
  assign w_x1   = (fault_en && fault_node == NODE_X1)   ? stuck_val : (i_a ^ i_b);
  assign o_sum  = (fault_en && fault_node == NODE_SUM)  ? stuck_val : (w_x1 ^ i_cin);
  assign o_cout = (fault_en && fault_node == NODE_COUT) ? stuck_val
                                                        : ((i_a & i_b) | (w_x1 & i_cin));

endmodule

`default_nettype wire

// File: rtl/adder_fault_campaign.sv
// ============================================================================
// Module      : adder_fault_campaign
// Description : Exhaustive stuck-at fault campaign over a ripple-carry adder.
//               Define ADDER_FAULT_EARLY_EXIT_EN to end each fault's sweep at
//               its first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_fault_campaign
  import adder_fault_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int NF    = NODES_PER_BIT * WIDTH,
  localparam int VW    = 2 * WIDTH + 1,
  localparam int FIW   = $clog2(NF),
  localparam int DCW   = $clog2(NF + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           fault_valid,
  output logic [FIW-1:0] fault_idx,
  output logic           fault_detected,
  output logic [VW-1:0]  first_vec,
  output logic [DCW-1:0] detected_count
);

  logic [1:0]     r_state;
  logic [1:0]     w_next;
  logic [FIW-1:0] r_fidx;
  logic [VW-1:0]  r_vcnt;
  logic           r_hit;
  logic [VW-1:0]  r_fvec;
  logic [DCW-1:0] r_dcnt;

  logic           r_busy;
  logic           r_done;
  logic           r_fv;
  logic [FIW-1:0] r_oidx;
  logic           r_odet;
  logic [VW-1:0]  r_ofvec;

  logic           w_busy_nxt;
  logic           w_done_nxt;
  logic           w_fv_nxt;
  logic           w_hit_nxt;
  logic [VW-1:0]  w_fvec_nxt;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_cg;
  logic [WIDTH:0]   w_cf;
  logic [WIDTH-1:0] w_sg;
  logic [WIDTH-1:0] w_sf;
  logic [FIW-1:0]   w_fbit;
  logic [FIW-1:0]   w_fmod;
  logic [1:0]       w_node;
  logic             w_mis;
  logic             w_vlast;
  logic             w_flast;

  assign w_a     = r_vcnt[VW-1:WIDTH+1];
  assign w_b     = r_vcnt[WIDTH:1];
  assign w_cg[0] = r_vcnt[0];
  assign w_cf[0] = r_vcnt[0];

  assign w_fbit  = r_fidx / FIW'(NODES_PER_BIT);
  assign w_fmod  = r_fidx % FIW'(NODES_PER_BIT);
  assign w_node  = 2'(w_fmod >> 1);

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      fa_fault_cell u_good (
        .i_a        (w_a[i]),
        .i_b        (w_b[i]),
        .i_cin      (w_cg[i]),
        .fault_en   (1'b0),
        .fault_node (NODE_X1),
        .stuck_val  (1'b0),
        .o_sum      (w_sg[i]),
        .o_cout     (w_cg[i+1])
      );
      fa_fault_cell u_faulty (
        .i_a        (w_a[i]),
        .i_b        (w_b[i]),
        .i_cin      (w_cf[i]),
        .fault_en   (w_fbit == FIW'(i)),
        .fault_node (w_node),
        .stuck_val  (w_fmod[0]),
        .o_sum      (w_sf[i]),
        .o_cout     (w_cf[i+1])
      );
    end
  endgenerate

  assign w_mis   = (w_sg != w_sf) || (w_cg[WIDTH] != w_cf[WIDTH]);
  assign w_vlast = &r_vcnt;
  assign w_flast = (r_fidx == FIW'(NF - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_RUN;
`ifdef ADDER_FAULT_EARLY_EXIT_EN
      ST_RUN:    if (w_mis || w_vlast) w_next = ST_REPORT;
`else
      ST_RUN:    if (w_vlast) w_next = ST_REPORT;
`endif
      ST_REPORT: w_next = w_flast ? ST_DONE : ST_RUN;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output registers are loaded from the upcoming state so they line up with it.
  always_comb begin
    w_busy_nxt = (w_next == ST_RUN) || (w_next == ST_REPORT);
    w_done_nxt = (w_next == ST_DONE);
    w_fv_nxt   = (w_next == ST_REPORT);
    w_hit_nxt  = r_hit | w_mis;
    w_fvec_nxt = (!r_hit && w_mis) ? r_vcnt : r_fvec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fidx <= '0;
      r_vcnt <= '0;
      r_hit  <= 1'b0;
      r_fvec <= '0;
      r_dcnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_fidx <= '0;
            r_vcnt <= '0;
            r_hit  <= 1'b0;
            r_fvec <= '0;
            r_dcnt <= '0;
          end
        end
        ST_RUN: begin
          r_vcnt <= r_vcnt + VW'(1);
          r_hit  <= w_hit_nxt;
          r_fvec <= w_fvec_nxt;
        end
        ST_REPORT: begin
          if (r_hit) r_dcnt <= r_dcnt + DCW'(1);
          if (!w_flast) begin
            r_fidx <= r_fidx + FIW'(1);
            r_vcnt <= '0;
            r_hit  <= 1'b0;
            r_fvec <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fv    <= 1'b0;
      r_oidx  <= '0;
      r_odet  <= 1'b0;
      r_ofvec <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_fv   <= w_fv_nxt;
      if (w_fv_nxt) begin
        r_oidx  <= r_fidx;
        r_odet  <= w_hit_nxt;
        r_ofvec <= w_fvec_nxt;
      end
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign fault_valid    = r_fv;
  assign fault_idx      = r_oidx;
  assign fault_detected = r_odet;
  assign first_vec      = r_ofvec;
  assign detected_count = r_dcnt;

endmodule

`default_nettype wire
